// File: rtl/mram_ctrl_pkg.sv
// mram_ctrl_pkg: shared FSM states, default parameters and strobe level for the MRAM sequencer
package mram_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, SHIFT, SETUP, ACCESS, RECOVER} state_t;
  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_T_ACCESS = 4;
  localparam int DEF_T_RECOVER = 2;
  localparam logic STROBE_OFF = 1'b1;
endpackage

// File: rtl/mram_lsb_serializer.sv
// mram_lsb_serializer: parallel-load LSB-first shifter for address and data with bit counter
module mram_lsb_serializer #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              addr_in,
  output logic              data_in,
  output logic              done
);
  localparam int KW = $clog2(ADDR_W + 1);
  logic [ADDR_W-1:0] a_sr, d_sr;
  logic [KW-1:0] k;
  assign addr_in = a_sr[0];
  assign data_in = d_sr[0];
  assign done = k == KW'(ADDR_W - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr <= '0;
      d_sr <= '0;
      k <= '0;
    end else if (load) begin
      a_sr <= addr;
      d_sr <= ADDR_W'(wdata);
      k <= '0;
    end else if (shift) begin
      a_sr <= a_sr >> 1;
      d_sr <= d_sr >> 1;
      k <= k + 1'b1;
    end
  end
endmodule

// File: rtl/mram_access_sequencer.sv
// mram_access_sequencer: serial-front-end MRAM single-word read/write sequencer with registered strobes
module mram_access_sequencer
  import mram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int T_ACCESS = DEF_T_ACCESS,
  parameter int T_RECOVER = DEF_T_RECOVER
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              ctrl_en,
  output logic              addr_in,
  output logic              data_in,
  output logic              chip_en,
  output logic              write_en,
  output logic              out_en,
  output logic              lower_byte_en,
  output logic              upper_byte_en,
  input  logic [DATA_W-1:0] mram_dq_in,
  output logic              dq_oe,
  output logic              busy
);
  state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic we_q;
  logic [1:0] be_q;
  logic accept, done, act_n, acc_n, last_acc;
  assign req_ready = state == IDLE;
  assign busy = !req_ready;
  assign accept = req_valid && req_ready;
  assign act_n = state_n == SETUP || state_n == ACCESS;
  assign acc_n = state_n == ACCESS;
  assign last_acc = state == ACCESS && cnt == '0;
  mram_lsb_serializer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ser (
    .clk(clk),
    .rst(rst),
    .load(accept),
    .shift(state == SHIFT),
    .addr(req_addr),
    .wdata(req_wdata),
    .addr_in(addr_in),
    .data_in(data_in),
    .done(done)
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: state_n = accept ? SHIFT : IDLE;
      SHIFT: state_n = done ? SETUP : SHIFT;
      SETUP: begin
        state_n = ACCESS;
        cnt_n = 16'(T_ACCESS - 1);
      end
      ACCESS: begin
        state_n = cnt == '0 ? RECOVER : ACCESS;
        cnt_n = cnt == '0 ? 16'(T_RECOVER - 1) : cnt - 1'b1;
      end
      RECOVER: begin
        state_n = cnt == '0 ? IDLE : RECOVER;
        cnt_n = cnt == '0 ? '0 : cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      we_q <= 1'b0;
      be_q <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      ctrl_en <= 1'b0;
      chip_en <= STROBE_OFF;
      write_en <= STROBE_OFF;
      out_en <= STROBE_OFF;
      lower_byte_en <= STROBE_OFF;
      upper_byte_en <= STROBE_OFF;
      dq_oe <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (accept) begin
        we_q <= req_we;
        be_q <= req_be;
      end
      rsp_valid <= last_acc;
      if (last_acc) rsp_rdata <= (!we_q && |be_q) ? mram_dq_in : '0;
      ctrl_en <= state_n == SHIFT;
      chip_en <= act_n ? ~STROBE_OFF : STROBE_OFF;
      lower_byte_en <= act_n && be_q[0] ? ~STROBE_OFF : STROBE_OFF;
      upper_byte_en <= act_n && be_q[1] ? ~STROBE_OFF : STROBE_OFF;
      write_en <= acc_n && we_q ? ~STROBE_OFF : STROBE_OFF;
      out_en <= acc_n && !we_q ? ~STROBE_OFF : STROBE_OFF;
      dq_oe <= acc_n && we_q;
    end
  end
endmodule
